alien_grid_render: RTL and testbench

ALIEN_GRID_RENDER -- requirements
Module: alien_grid_render

---
 rtl/alien_grid_render_pkg.sv | 31 +++
 rtl/alien_sprite_rom.sv | 27 ++
 rtl/alien_grid_render.sv | 160 ++++++++++++++++
 tb/tb_alien_grid_render.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alien_grid_render_pkg.sv
// Shared screen, timing, color and FSM definitions for the alien formation
// renderer and the VGA timing generator it sits behind.
package alien_grid_render_pkg;

    // 640x480 timing generator constants
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    localparam logic [9:0] LAND_Y = 10'd440;

    localparam logic [7:0] COLOR_ROW0  = 8'hE3;
    localparam logic [7:0] COLOR_ROWN  = 8'h1C;
    localparam logic [7:0] COLOR_BLACK = 8'h00;

    localparam int SPRITE_SZ = 16;
    localparam int PITCH     = 32;

    typedef enum logic [1:0] {
        S_RIGHT = 2'd0,
        S_LEFT  = 2'd1,
        S_DROP  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/alien_sprite_rom.sv
// 16x16 alien bitmap; bit n of a row is the pixel at x offset n.
module alien_sprite_rom (
    input  logic [3:0]  row_i,
    output logic [15:0] bits_o
);

    always_comb begin
        case (row_i)
            4'd0:    bits_o = 16'hC003;
            4'd1:    bits_o = 16'h6006;
            4'd2:    bits_o = 16'h3FFC;
            4'd3:    bits_o = 16'h7FFE;
            4'd4:    bits_o = 16'hFFFF;
            4'd5:    bits_o = 16'hE7E7;
            4'd6:    bits_o = 16'hE7E7;
            4'd7:    bits_o = 16'hFFFF;
            4'd8:    bits_o = 16'hFFFF;
            4'd9:    bits_o = 16'h7FFE;
            4'd10:   bits_o = 16'h3C3C;
            4'd11:   bits_o = 16'h6666;
            4'd12:   bits_o = 16'hC3C3;
            4'd13:   bits_o = 16'h8181;
            default: bits_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/alien_grid_render.sv
// Alien formation: frame-paced march/drop FSM, kill mask, and a one-pixel
// registered renderer that keeps syncs aligned with rgb.
module alien_grid_render
    import alien_grid_render_pkg::*;
#(
    parameter int COLS      = 8,
    parameter int ROWS      = 4,
    parameter int STEP_X    = 2,
    parameter int STEP_Y    = 8,
    parameter int FRAME_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    input  logic       hSync_in,
    input  logic       vSync_in,
    input  logic       kill_valid,
    input  logic [2:0] kill_col,
    input  logic [1:0] kill_row,
    output logic [7:0] rgb,
    output logic       hSync_out,
    output logic       vSync_out,
    output logic       alien_on,
    output logic [5:0] alive_count,
    output logic       all_dead,
    output logic       landed
);

    localparam int              NUM      = ROWS * COLS;
    localparam logic [10:0]     FORM_W   = 11'(COLS * PITCH - SPRITE_SZ);
    localparam logic [10:0]     FORM_H   = 11'(ROWS * PITCH - SPRITE_SZ);
    localparam int              FW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FW-1:0]   FDIV_MAX = FW'(FRAME_DIV - 1);

    logic [FW-1:0]             fcnt_q, fcnt_d;
    logic                      frame_tick, move_tick;
    state_e                    state_q, state_d, next_dir_q, next_dir_d;
    logic [9:0]                gridX_q, gridX_d, gridY_q, gridY_d;
    logic [ROWS-1:0][COLS-1:0] alive_q, alive_d;
    logic [5:0]                alive_count_q;
    logic [7:0]                rgb_q;
    logic                      alien_on_q, hsync_q, vsync_q;
    logic                      right_edge, left_edge;

    // Row 480 col 0 is the first blanking pixel, so the grid never moves mid-picture
    assign frame_tick = enable && (hPos == 10'd0) && (vPos == V_ACTIVE);
    assign move_tick  = frame_tick && (fcnt_q == FDIV_MAX);
    assign fcnt_d     = !frame_tick ? fcnt_q : (move_tick ? '0 : fcnt_q + 1'b1);

    assign landed     = (11'(gridY_q) + FORM_H) >= 11'(LAND_Y);
    assign all_dead   = (alive_count_q == 6'd0);
    assign right_edge = (11'(gridX_q) + FORM_W + 11'(STEP_X)) > 11'(H_ACTIVE);
    assign left_edge  = gridX_q < 10'(STEP_X);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RIGHT;
            next_dir_q <= S_LEFT;
            gridX_q    <= 10'd64;
            gridY_q    <= 10'd32;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            next_dir_q <= next_dir_d;
            gridX_q    <= gridX_d;
            gridY_q    <= gridY_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (move_tick && state_q != S_HALT) begin
            if (landed || all_dead) begin
                state_d = S_HALT;
            end else begin
                case (state_q)
                    S_RIGHT: if (right_edge) state_d = S_DROP;
                    S_LEFT:  if (left_edge)  state_d = S_DROP;
                    S_DROP:  state_d = next_dir_q;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        gridX_d    = gridX_q;
        gridY_d    = gridY_q;
        next_dir_d = next_dir_q;
        if (move_tick && !landed && !all_dead) begin
            case (state_q)
                S_RIGHT: if (right_edge) next_dir_d = S_LEFT;
                         else            gridX_d    = gridX_q + 10'(STEP_X);
                S_LEFT:  if (left_edge)  next_dir_d = S_RIGHT;
                         else            gridX_d    = gridX_q - 10'(STEP_X);
                S_DROP:  gridY_d = gridY_q + 10'(STEP_Y);
                default: ;
            endcase
        end
    end

    // Kills land regardless of the pixel enable; dead or out-of-range targets are no-ops
    always_comb begin
        alive_d = alive_q;
        if (kill_valid && (32'(kill_row) < ROWS) && (32'(kill_col) < COLS))
            alive_d[kill_row][kill_col] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive_q       <= '1;
            alive_count_q <= 6'(NUM);
        end else begin
            alive_q       <= alive_d;
            alive_count_q <= 6'($countones(alive_d));
        end
    end

    logic [9:0]  relX, relY;
    logic [15:0] spr_row;
    logic        in_form, hit;

    assign relX = hPos - gridX_q;
    assign relY = vPos - gridY_q;
    assign in_form = (hPos >= gridX_q) && (11'(relX) < FORM_W) &&
                     (vPos >= gridY_q) && (11'(relY) < FORM_H) &&
                     (hPos < H_ACTIVE) && (vPos < V_ACTIVE);

    alien_sprite_rom u_rom (
        .row_i  (relY[3:0]),
        .bits_o (spr_row)
    );

    assign hit = in_form && !relX[4] && !relY[4] &&
                 alive_q[relY[6:5]][relX[7:5]] && spr_row[relX[3:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q      <= COLOR_BLACK;
            alien_on_q <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else if (enable) begin
            rgb_q      <= !hit ? COLOR_BLACK : (relY[6:5] == 2'd0 ? COLOR_ROW0 : COLOR_ROWN);
            alien_on_q <= hit;
            hsync_q    <= hSync_in;
            vsync_q    <= vSync_in;
        end
    end

    assign rgb         = rgb_q;
    assign alien_on    = alien_on_q;
    assign hSync_out   = hsync_q;
    assign vSync_out   = vsync_q;
    assign alive_count = alive_count_q;

endmodule

// File: tb/tb_alien_grid_render.sv
// Randomized bench for alien_grid_render against a screen-level model of the
// formation (grid origin, march rules, kill mask and sprite bitmap).
module tb_alien_grid_render;
    import alien_grid_render_pkg::*;

    localparam int FDIV = 2;

    logic       clk = 1'b0;
    logic       reset, enable, hSync_in, vSync_in, kill_valid;
    logic [9:0] hPos, vPos;
    logic [2:0] kill_col;
    logic [1:0] kill_row;
    logic [7:0] rgb;
    logic       hSync_out, vSync_out, alien_on, all_dead, landed;
    logic [5:0] alive_count;

    int     checks = 0, errors = 0;
    int     m_gx, m_gy, m_fc;
    state_e m_st, m_nd;
    bit     m_alive[32];
    logic [7:0] exp_rgb;
    logic   exp_on, exp_hs, exp_vs;

    always #5 clk = ~clk;

    alien_grid_render #(.FRAME_DIV(FDIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .hPos(hPos), .vPos(vPos),
        .hSync_in(hSync_in), .vSync_in(vSync_in), .kill_valid(kill_valid),
        .kill_col(kill_col), .kill_row(kill_row), .rgb(rgb), .hSync_out(hSync_out),
        .vSync_out(vSync_out), .alien_on(alien_on), .alive_count(alive_count),
        .all_dead(all_dead), .landed(landed)
    );

    function automatic logic [15:0] sprite_row(int r);
        case (r)
            0: return 16'hC003;  1: return 16'h6006;  2: return 16'h3FFC;  3: return 16'h7FFE;
            4: return 16'hFFFF;  5: return 16'hE7E7;  6: return 16'hE7E7;  7: return 16'hFFFF;
            8: return 16'hFFFF;  9: return 16'h7FFE; 10: return 16'h3C3C; 11: return 16'h6666;
           12: return 16'hC3C3; 13: return 16'h8181;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_alive[i]);
        return n;
    endfunction

    function automatic logic [7:0] model_pixel(int h, int v);
        int rx, ry;
        logic [15:0] s;
        if (h >= 640 || v >= 480) return 8'h00;
        rx = h - m_gx;
        ry = v - m_gy;
        if (rx < 0 || ry < 0 || rx >= 8*32-16 || ry >= 4*32-16) return 8'h00;
        if (rx % 32 >= 16 || ry % 32 >= 16) return 8'h00;
        if (!m_alive[(ry/32)*8 + rx/32]) return 8'h00;
        s = sprite_row(ry % 16);
        if (!s[rx % 16]) return 8'h00;
        return (ry < 32) ? 8'hE3 : 8'h1C;
    endfunction

    function automatic void model_reset();
        m_gx = 64; m_gy = 32; m_fc = 0; m_st = S_RIGHT; m_nd = S_LEFT;
        for (int i = 0; i < 32; i++) m_alive[i] = 1'b1;
        exp_rgb = 8'h00; exp_on = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
    endfunction

    function automatic void model_move();
        if (m_st == S_HALT) return;
        if (m_gy + 112 >= 440 || m_count() == 0) begin
            m_st = S_HALT;
            return;
        end
        case (m_st)
            S_RIGHT: if (m_gx + 240 + 2 > 640) begin m_st = S_DROP; m_nd = S_LEFT; end
                     else m_gx += 2;
            S_LEFT:  if (m_gx < 2) begin m_st = S_DROP; m_nd = S_RIGHT; end
                     else m_gx -= 2;
            S_DROP:  begin m_gy += 8; m_st = m_nd; end
            default: ;
        endcase
    endfunction

    // One clock with the currently driven inputs; the model sees the same inputs.
    task automatic cycle();
        @(posedge clk); #1;
        if (enable) begin
            exp_rgb = model_pixel(int'(hPos), int'(vPos));
            exp_on  = (exp_rgb != 8'h00);
            exp_hs  = hSync_in;
            exp_vs  = vSync_in;
            if (hPos == 10'd0 && vPos == 10'd480) begin
                m_fc++;
                if (m_fc == FDIV) begin m_fc = 0; model_move(); end
            end
        end
        if (kill_valid) m_alive[int'(kill_row)*8 + int'(kill_col)] = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b0; kill_valid = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        #4;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; hPos = '0; vPos = '0; hSync_in = 1'b1; vSync_in = 1'b1;
        kill_valid = 1'b0; kill_col = '0; kill_row = '0;
        #13;
        model_reset();
        checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb got %h want 00", rgb); end
        checks++; if (alien_on !== 1'b0) begin errors++; $display("FAIL reset_alien_on got %b want 0", alien_on); end
        checks++; if ({hSync_out, vSync_out} !== 2'b11) begin errors++; $display("FAIL reset_sync got %b%b want 11", hSync_out, vSync_out); end
        checks++; if (alive_count !== 6'd32) begin errors++; $display("FAIL reset_alive_count got %0d want 32", alive_count); end
        checks++; if ({all_dead, landed} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b%b want 00", all_dead, landed); end
        checks++; if (dut.gridX_q !== 10'd64 || dut.gridY_q !== 10'd32) begin errors++; $display("FAIL reset_grid got %0d,%0d want 64,32", dut.gridX_q, dut.gridY_q); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_pixel_basic();
        enable = 1'b1; hPos = 10'd64; vPos = 10'd32;
        cycle();
        checks++; if (rgb !== 8'hE3 || alien_on !== 1'b1) begin errors++; $display("FAIL pixel_origin got rgb=%h on=%b want E3 1", rgb, alien_on); end
        hPos = 10'd80;
        cycle();
        checks++; if (rgb !== 8'h00 || alien_on !== 1'b0) begin errors++; $display("FAIL pixel_gap got rgb=%h on=%b want 00 0", rgb, alien_on); end
    endtask

    task automatic test_pixel_random();
        for (int i = 0; i < 400; i++) begin
            enable   = ($urandom_range(0, 3) != 0);
            hSync_in = 1'($urandom);
            vSync_in = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                hPos = 10'($urandom); vPos = 10'($urandom);
            end else begin
                hPos = 10'($urandom_range(40, 330)); vPos = 10'($urandom_range(20, 160));
            end
            cycle();
            checks++; if (rgb !== exp_rgb || alien_on !== exp_on) begin errors++; $display("FAIL pixel_random(%0d,%0d) got %h/%b want %h/%b", hPos, vPos, rgb, alien_on, exp_rgb, exp_on); end
            checks++; if (hSync_out !== exp_hs || vSync_out !== exp_vs) begin errors++; $display("FAIL sync_random got %b%b want %b%b", hSync_out, vSync_out, exp_hs, exp_vs); end
        end
    endtask

    task automatic test_sync();
        logic [7:0] held_rgb;
        enable = 1'b1; vPos = 10'd100; hPos = 10'd655; hSync_in = 1'b1; vSync_in = 1'b1;
        cycle();
        hPos = 10'd656; hSync_in = 1'b0;
        checks++; if (hSync_out !== 1'b1) begin errors++; $display("FAIL hsync_before got %b want 1", hSync_out); end
        cycle();
        checks++; if (hSync_out !== 1'b0) begin errors++; $display("FAIL hsync_latency got %b want 0", hSync_out); end
        hPos = 10'd64; vPos = 10'd32;
        cycle();
        held_rgb = rgb;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hSync_in = ~hSync_in; vSync_in = ~vSync_in; hPos = hPos + 10'd7;
            cycle();
            checks++; if (rgb !== held_rgb || rgb !== exp_rgb || hSync_out !== 1'b0 || vSync_out !== 1'b1) begin errors++; $display("FAIL hold_disabled got %h %b%b want %h 01", rgb, hSync_out, vSync_out, held_rgb); end
        end
        enable = 1'b1; hSync_in = 1'b1; vSync_in = 1'b1;
    endtask

    task automatic test_kill();
        enable = 1'b1; hPos = 10'd160; vPos = 10'd64;
        cycle();
        checks++; if (rgb !== 8'h1C || rgb !== exp_rgb) begin errors++; $display("FAIL kill_pre_pixel got %h want 1C", rgb); end
        enable = 1'b0; kill_valid = 1'b1; kill_row = 2'd1; kill_col = 3'd3;
        cycle();
        checks++; if (alive_count !== 6'd31) begin errors++; $display("FAIL kill_first got %0d want 31", alive_count); end
        cycle();
        kill_valid = 1'b0;
        checks++; if (alive_count !== 6'd31 || alive_count !== 6'(m_count())) begin errors++; $display("FAIL kill_repeat got %0d want 31", alive_count); end
        enable = 1'b1;
        cycle();
        checks++; if (rgb !== 8'h00 || alien_on !== 1'b0) begin errors++; $display("FAIL kill_pixel_black got %h/%b want 00/0", rgb, alien_on); end
    endtask

    task automatic test_march_and_land();
        int n = 0;
        int frozen_x;
        do_reset();
        hSync_in = 1'b1; vSync_in = 1'b1;
        while (m_st != S_HALT && n < 40000) begin
            enable = 1'b1; hPos = 10'd0; vPos = 10'd480;
            kill_valid = (n < 400) && ($urandom_range(0, 19) == 0);
            kill_row = 2'($urandom); kill_col = 3'($urandom);
            cycle();
            n++;
            if (n == 1) begin
                checks++; if (dut.gridX_q !== 10'd64) begin errors++; $display("FAIL early_move got %0d want 64", dut.gridX_q); end
            end
            if (n == FDIV) begin
                checks++; if (dut.gridX_q !== 10'd66) begin errors++; $display("FAIL first_move got %0d want 66", dut.gridX_q); end
            end
            checks++; if (int'(dut.gridX_q) != m_gx || int'(dut.gridY_q) != m_gy || dut.state_q !== m_st) begin errors++; $display("FAIL march frame %0d got x=%0d y=%0d st=%0d want %0d %0d %0d", n, dut.gridX_q, dut.gridY_q, dut.state_q, m_gx, m_gy, m_st); end
            checks++; if (alive_count !== 6'(m_count()) || landed !== (m_gy + 112 >= 440)) begin errors++; $display("FAIL march_status got cnt=%0d land=%b want %0d %b", alive_count, landed, m_count(), (m_gy + 112 >= 440)); end
            if (n % 16 == 0) begin
                kill_valid = 1'b0;
                hPos = 10'(m_gx - 20 + int'($urandom_range(0, 280)));
                vPos = 10'(m_gy - 20 + int'($urandom_range(0, 150)));
                cycle();
                checks++; if (rgb !== exp_rgb || alien_on !== exp_on) begin errors++; $display("FAIL march_pixel(%0d,%0d) got %h want %h", hPos, vPos, rgb, exp_rgb); end
            end
        end
        kill_valid = 1'b0;
        checks++; if (m_st != S_HALT || landed !== 1'b1 || dut.state_q !== S_HALT) begin errors++; $display("FAIL land_halt got landed=%b st=%0d want 1 %0d", landed, dut.state_q, S_HALT); end
        frozen_x = int'(dut.gridX_q);
        for (int i = 0; i < 10 * FDIV; i++) cycle();
        checks++; if (int'(dut.gridX_q) != frozen_x || int'(dut.gridY_q) != m_gy) begin errors++; $display("FAIL land_frozen got %0d,%0d want %0d,%0d", dut.gridX_q, dut.gridY_q, frozen_x, m_gy); end
        // asynchronous reset mid-line
        hPos = 10'd300; vPos = 10'd200;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        checks++; if (rgb !== 8'h00 || alien_on !== 1'b0 || {hSync_out, vSync_out} !== 2'b11) begin errors++; $display("FAIL midreset_pixel got %h %b %b%b want 00 0 11", rgb, alien_on, hSync_out, vSync_out); end
        checks++; if (alive_count !== 6'd32 || all_dead !== 1'b0 || landed !== 1'b0) begin errors++; $display("FAIL midreset_status got %0d %b %b want 32 0 0", alive_count, all_dead, landed); end
        checks++; if (dut.state_q !== S_RIGHT || dut.next_dir_q !== S_LEFT || dut.fcnt_q != 0 || dut.gridX_q !== 10'd64 || dut.gridY_q !== 10'd32) begin errors++; $display("FAIL midreset_state got st=%0d nd=%0d fc=%0d x=%0d y=%0d", dut.state_q, dut.next_dir_q, dut.fcnt_q, dut.gridX_q, dut.gridY_q); end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_all_dead();
        int order[32];
        int frozen_x;
        do_reset();
        for (int i = 0; i < 32; i++) order[i] = i;
        for (int i = 31; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        enable = 1'b0; kill_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            kill_row = 2'(order[i] / 8); kill_col = 3'(order[i] % 8);
            cycle();
            checks++; if (alive_count !== 6'(m_count())) begin errors++; $display("FAIL kill_sweep got %0d want %0d", alive_count, m_count()); end
            if (i == 5) begin
                cycle();
                checks++; if (alive_count !== 6'(m_count())) begin errors++; $display("FAIL kill_dead_again got %0d want %0d", alive_count, m_count()); end
            end
        end
        kill_valid = 1'b0;
        checks++; if (all_dead !== 1'b1 || alive_count !== 6'd0) begin errors++; $display("FAIL all_dead got %b cnt=%0d want 1 0", all_dead, alive_count); end
        frozen_x = int'(dut.gridX_q);
        enable = 1'b1; hPos = 10'd0; vPos = 10'd480;
        for (int i = 0; i < 10 * FDIV; i++) begin
            cycle();
            checks++; if (dut.state_q !== m_st || int'(dut.gridX_q) != frozen_x) begin errors++; $display("FAIL dead_halt got st=%0d x=%0d want %0d %0d", dut.state_q, dut.gridX_q, m_st, frozen_x); end
        end
        checks++; if (dut.state_q !== S_HALT) begin errors++; $display("FAIL dead_state got %0d want %0d", dut.state_q, S_HALT); end
    endtask

    initial begin
        test_reset();
        test_pixel_basic();
        test_pixel_random();
        test_sync();
        test_kill();
        test_march_and_land();
        test_all_dead();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
